defuzzifier_wavg: RTL and testbench

- Output end of the fuzzy datapath. The fuzzifier turns a crisp input into membership degrees; this block does the reverse.
- It turns N_RULES rule firing strengths (16-bit unsigned degrees, same format the trapezoid membership units produce) into one crisp signed 8-bit output.
- Method: singleton weighted average, y = sum(mu_i*s_i) / sum(mu_i).
- Sequential implementation: one multiply-accumulate per cycle, then an iterative restoring divider, with valid/ready handshakes on both sides.

---
 rtl/defuzzifier_wavg_pkg.sv | 35 +++
 rtl/defuzzifier_wavg_if.sv | 25 ++
 rtl/defuzzifier_wavg_chk.sv | 20 ++
 rtl/defuzzifier_wavg_div.sv | 80 ++++++++
 rtl/defuzzifier_wavg.sv | 194 +++++++++++++++++++
 tb/tb_defuzzifier_wavg.sv | 199 +++++++++++++++++++
 6 files changed

// File: rtl/defuzzifier_wavg_pkg.sv
// Shared fuzzy datapath types: membership degrees, crisp values, defuzzifier
// FSM states, and the sign/saturation helper used on the divider result.
package defuzzifier_wavg_pkg;

   typedef logic [15:0]        mu_t;
   typedef logic signed [7:0]  crisp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } defuzz_state_e;

   localparam int Q_BITS = 8;

   // Apply the numerator sign to an unsigned quotient and clip to the crisp
   // range; only a positive 128 can exceed it because |num| <= 128*den.
   function automatic crisp_t apply_sign_sat(input logic neg, input logic [Q_BITS-1:0] q);
      logic [Q_BITS:0] q_ext;
      logic [Q_BITS:0] q_neg;
      crisp_t          res;
      q_ext = {1'b0, q};
      q_neg = 9'd0 - q_ext;
      if (neg) begin
         res = q_neg[7:0];
      end else if (q_ext > 9'd127) begin
         res = 8'sd127;
      end else begin
         res = q_ext[7:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/defuzzifier_wavg_if.sv
// Rule-vector in / crisp-result out handshake bundle of the defuzzifier.
interface defuzzifier_wavg_if
   import defuzzifier_wavg_pkg::*;
#(
   parameter int N_RULES = 9
);
   logic                   in_valid;
   logic                   in_ready;
   logic [16*N_RULES-1:0]  mu;
   logic [8*N_RULES-1:0]   s;
   logic                   out_valid;
   logic                   out_ready;
   crisp_t                 y;
   logic                   zero_den;

   modport master (
      output in_valid, mu, s, out_ready,
      input  in_ready, out_valid, y, zero_den
   );

   modport slave (
      input  in_valid, mu, s, out_ready,
      output in_ready, out_valid, y, zero_den
   );
endinterface

// File: rtl/defuzzifier_wavg_chk.sv
// Elaboration-time parameter checks for the defuzzifier accumulators.
module defuzzifier_wavg_chk #(
   parameter int N_RULES = 9,
   parameter int DEN_W   = 20,
   parameter int NUM_W   = 28
) ();

   localparam int LOG_N = (N_RULES > 1) ? $clog2(N_RULES) : 0;

   if (N_RULES < 1 || N_RULES > 16) begin : g_bad_n
      $error("defuzzifier_wavg: N_RULES=%0d outside 1..16", N_RULES);
   end
   if (DEN_W < 16 + LOG_N) begin : g_bad_den
      $error("defuzzifier_wavg: DEN_W=%0d too narrow for N_RULES=%0d", DEN_W, N_RULES);
   end
   if (NUM_W < 24 + LOG_N) begin : g_bad_num
      $error("defuzzifier_wavg: NUM_W=%0d too narrow for N_RULES=%0d", NUM_W, N_RULES);
   end

endmodule

// File: rtl/defuzzifier_wavg_div.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// done is high during the cycle whose edge resolves the last bit; quotient
// already includes that bit, so the caller can capture it on the same edge.
module seq_div_restoring
   import defuzzifier_wavg_pkg::*;
#(
   parameter int DVD_W = 28,
   parameter int DVS_W = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DVD_W-1:0]  dividend,
   input  logic [DVS_W-1:0]  divisor,
   output logic [Q_BITS-1:0] quotient,
   output logic              done
);

   localparam int K_W  = $clog2(Q_BITS);
   localparam int SH_W = DVS_W + Q_BITS - 1;
   localparam int CW   = ((DVD_W > SH_W) ? DVD_W : SH_W) + 1;

   logic [DVD_W-1:0]  rem_r;
   logic [DVS_W-1:0]  dvs_r;
   logic [Q_BITS-1:0] q_r;
   logic [K_W-1:0]    k_r;
   logic              busy_r;

   logic [CW-1:0]     shifted_s;
   logic [CW-1:0]     rem_ext_s;
   logic [CW-1:0]     diff_s;
   logic              ge_s;
   logic [DVD_W-1:0]  rem_nxt_s;
   logic [Q_BITS-1:0] q_step_s;

   // One trial subtraction of the divisor shifted to the current bit weight.
   always_comb begin
      shifted_s = CW'(dvs_r) << k_r;
      rem_ext_s = CW'(rem_r);
      diff_s    = rem_ext_s - shifted_s;
      ge_s      = (rem_ext_s >= shifted_s);
      rem_nxt_s = rem_r;
      q_step_s  = q_r;
      if (ge_s) begin
         rem_nxt_s = diff_s[DVD_W-1:0];
         q_step_s  = q_r | (Q_BITS'(1) << k_r);
      end else begin
         rem_nxt_s = rem_r;
         q_step_s  = q_r;
      end
   end

   assign quotient = q_step_s;
   assign done     = busy_r && (k_r == K_W'(0));

   // Load operands on start, then retire one quotient bit per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_r  <= {DVD_W{1'b0}};
         dvs_r  <= {DVS_W{1'b0}};
         q_r    <= {Q_BITS{1'b0}};
         k_r    <= {K_W{1'b0}};
         busy_r <= 1'b0;
      end else if (start) begin
         rem_r  <= dividend;
         dvs_r  <= divisor;
         q_r    <= {Q_BITS{1'b0}};
         k_r    <= K_W'(Q_BITS - 1);
         busy_r <= 1'b1;
      end else if (busy_r) begin
         rem_r  <= rem_nxt_s;
         q_r    <= q_step_s;
         k_r    <= k_r - K_W'(1);
         busy_r <= (k_r != K_W'(0));
      end else begin
         busy_r <= 1'b0;
      end
   end

endmodule

// File: rtl/defuzzifier_wavg.sv
// Weighted-average singleton defuzzifier: y = sum(mu_i*s_i) / sum(mu_i).
// One MAC per cycle over the captured rule vector, then an 8-cycle restoring
// divide on |num|; sign, truncation toward zero and saturation applied last.
module defuzzifier_wavg
   import defuzzifier_wavg_pkg::*;
#(
   parameter int N_RULES = 9,
   parameter int DEN_W   = 20,
   parameter int NUM_W   = 28
) (
   input  logic              clk,
   input  logic              rst_n,
   defuzzifier_wavg_if.slave bus
);

   localparam int IDX_W  = (N_RULES > 1) ? $clog2(N_RULES) : 1;
   localparam int PROD_W = 25;

   defuzz_state_e            state_r;
   defuzz_state_e            state_nxt_s;

   mu_t                      mu_r [N_RULES];
   crisp_t                   s_r  [N_RULES];
   logic [IDX_W-1:0]         idx_r;
   logic signed [NUM_W-1:0]  num_r;
   logic [DEN_W-1:0]         den_r;
   logic                     neg_r;
   logic                     den_zero_r;
   logic                     out_valid_r;
   crisp_t                   y_r;
   logic                     zero_den_r;

   logic signed [PROD_W-1:0] mu_ext_s;
   logic signed [PROD_W-1:0] s_ext_s;
   logic signed [PROD_W-1:0] prod_s;
   logic signed [NUM_W-1:0]  num_nxt_s;
   logic [DEN_W-1:0]         den_nxt_s;
   logic [NUM_W-1:0]         num_abs_s;
   logic                     last_acc_s;
   logic                     div_start_s;
   logic                     div_done_s;
   logic [Q_BITS-1:0]        div_q_s;

   defuzzifier_wavg_chk #(
      .N_RULES (N_RULES),
      .DEN_W   (DEN_W),
      .NUM_W   (NUM_W)
   ) u_chk ();

   seq_div_restoring #(
      .DVD_W (NUM_W),
      .DVS_W (DEN_W)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start_s),
      .dividend (num_abs_s),
      .divisor  (den_nxt_s),
      .quotient (div_q_s),
      .done     (div_done_s)
   );

   assign last_acc_s    = (idx_r == IDX_W'(N_RULES - 1));
   assign bus.in_ready  = (state_r == IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.y         = y_r;
   assign bus.zero_den  = zero_den_r;

   // MAC term for the current rule; the unsigned degree is zero-extended so
   // the product is signed, and |num| feeds the divider on the last term.
   always_comb begin
      mu_ext_s  = $signed({{(PROD_W-16){1'b0}}, mu_r[idx_r]});
      s_ext_s   = PROD_W'(s_r[idx_r]);
      prod_s    = mu_ext_s * s_ext_s;
      num_nxt_s = num_r + NUM_W'(prod_s);
      den_nxt_s = den_r + DEN_W'(mu_r[idx_r]);
      num_abs_s = $unsigned(num_nxt_s);
      if (num_nxt_s[NUM_W-1]) begin
         num_abs_s = $unsigned(-num_nxt_s);
      end else begin
         num_abs_s = $unsigned(num_nxt_s);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and divider start on the final accumulation cycle.
   always_comb begin
      state_nxt_s = state_r;
      div_start_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               state_nxt_s = ACC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACC: begin
            if (last_acc_s) begin
               state_nxt_s = DIV;
               div_start_s = 1'b1;
            end else begin
               state_nxt_s = ACC;
            end
         end
         DIV: begin
            if (div_done_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = DIV;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Capture, accumulation and result registers; results hold after accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_RULES; i++) begin
            mu_r[i] <= 16'd0;
            s_r[i]  <= 8'sd0;
         end
         idx_r       <= {IDX_W{1'b0}};
         num_r       <= {NUM_W{1'b0}};
         den_r       <= {DEN_W{1'b0}};
         neg_r       <= 1'b0;
         den_zero_r  <= 1'b0;
         out_valid_r <= 1'b0;
         y_r         <= 8'sd0;
         zero_den_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  for (int i = 0; i < N_RULES; i++) begin
                     mu_r[i] <= bus.mu[16*i +: 16];
                     s_r[i]  <= bus.s[8*i +: 8];
                  end
                  idx_r <= {IDX_W{1'b0}};
                  num_r <= {NUM_W{1'b0}};
                  den_r <= {DEN_W{1'b0}};
               end
            end
            ACC: begin
               num_r <= num_nxt_s;
               den_r <= den_nxt_s;
               idx_r <= idx_r + IDX_W'(1);
               if (last_acc_s) begin
                  neg_r      <= num_nxt_s[NUM_W-1];
                  den_zero_r <= (den_nxt_s == {DEN_W{1'b0}});
               end
            end
            DIV: begin
               if (div_done_s) begin
                  out_valid_r <= 1'b1;
                  zero_den_r  <= den_zero_r;
                  if (den_zero_r) begin
                     y_r <= 8'sd0;
                  end else begin
                     y_r <= apply_sign_sat(neg_r, div_q_s);
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_defuzzifier_wavg.sv
// Self-checking bench for defuzzifier_wavg: directed cases plus randomized
// rule vectors compared against a plain-arithmetic weighted-average model.
module tb_defuzzifier_wavg;
   import defuzzifier_wavg_pkg::*;

   localparam int N   = 9;
   localparam int LAT = N + Q_BITS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   defuzzifier_wavg_if #(.N_RULES(N)) bus ();

   defuzzifier_wavg #(
      .N_RULES (N),
      .DEN_W   (20),
      .NUM_W   (28)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [16*N-1:0] mu_v;
   logic [8*N-1:0]  s_v;

   task automatic check_val(input string tag, input longint obs, input longint expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Weighted average with integer division truncating toward zero.
   task automatic model(output longint ey, output longint ez);
      longint num, den, m, sv, q;
      num = 0;
      den = 0;
      for (int i = 0; i < N; i++) begin
         m   = longint'(mu_v[16*i +: 16]);
         sv  = longint'($signed(s_v[8*i +: 8]));
         num += m * sv;
         den += m;
      end
      if (den == 0) begin
         ey = 0;
         ez = 1;
      end else begin
         q = num / den;
         if (q > 127)  q = 127;
         if (q < -128) q = -128;
         ey = q;
         ez = 0;
      end
   endtask

   task automatic clear_vec();
      mu_v = '0;
      s_v  = '0;
   endtask

   task automatic set_rule(input int i, input int m, input int sv);
      mu_v[16*i +: 16] = 16'(m);
      s_v[8*i +: 8]    = 8'(sv);
   endtask

   // Caller is at a negedge with the DUT idle. Sends mu_v/s_v, checks
   // latency and result, holds out_ready low for 'hold' cycles, then accepts.
   task automatic run_txn(input string tag, input int hold);
      longint ey, ez;
      int cyc;
      model(ey, ez);
      check_val({tag, "/in_ready_idle"}, longint'(bus.in_ready), 1);
      bus.mu       = mu_v;
      bus.s        = s_v;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.mu       = ~mu_v;
      bus.s        = ~s_v;
      cyc = 0;
      while (cyc < 200) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == 1) check_val({tag, "/in_ready_busy"}, longint'(bus.in_ready), 0);
         if (bus.out_valid) break;
      end
      check_val({tag, "/latency"}, cyc, LAT);
      check_val({tag, "/y"}, longint'($signed(bus.y)), ey);
      check_val({tag, "/zero_den"}, longint'(bus.zero_den), ez);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = i[0];
         bus.mu       = {N{16'h7FFF}};
         bus.s        = {N{8'h11}};
         @(posedge clk);
         @(negedge clk);
         check_val({tag, "/hold_valid"}, longint'(bus.out_valid), 1);
         check_val({tag, "/hold_y"}, longint'($signed(bus.y)), ey);
         check_val({tag, "/hold_in_ready"}, longint'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_val({tag, "/accept_valid"}, longint'(bus.out_valid), 0);
      check_val({tag, "/accept_in_ready"}, longint'(bus.in_ready), 1);
      check_val({tag, "/kept_y"}, longint'($signed(bus.y)), ey);
      check_val({tag, "/kept_zd"}, longint'(bus.zero_den), ez);
   endtask

   task automatic random_vec();
      for (int i = 0; i < N; i++) begin
         case ($urandom_range(0, 3))
            0: mu_v[16*i +: 16] = 16'd0;
            1: mu_v[16*i +: 16] = 16'hFFFF;
            2: mu_v[16*i +: 16] = 16'($urandom_range(0, 15));
            default: mu_v[16*i +: 16] = 16'($urandom);
         endcase
         s_v[8*i +: 8] = 8'($urandom);
      end
   endtask

   initial begin
      int seen;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.mu        = '0;
      bus.s         = '0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset/in_ready", longint'(bus.in_ready), 1);
      check_val("reset/out_valid", longint'(bus.out_valid), 0);
      check_val("reset/y", longint'($signed(bus.y)), 0);
      check_val("reset/zero_den", longint'(bus.zero_den), 0);
      rst_n = 1'b1;
      @(negedge clk);

      clear_vec(); set_rule(0, 16'h8000, 50);
      run_txn("single", 0);
      clear_vec(); set_rule(0, 16'h4000, 100); set_rule(1, 16'hC000, -20);
      run_txn("mixed", 0);
      clear_vec(); set_rule(0, 1, -5); set_rule(1, 1, 0);
      run_txn("trunc", 0);
      clear_vec(); set_rule(0, 16'hFFFF, -100); set_rule(1, 16'hFFFF, 100);
      run_txn("symm", 0);
      clear_vec();
      for (int i = 0; i < N; i++) set_rule(i, 16'hFFFF, -128);
      run_txn("min", 0);
      clear_vec();
      for (int i = 0; i < N; i++) set_rule(i, 0, int'($urandom_range(0, 255)) - 128);
      run_txn("zero_den", 0);
      clear_vec(); set_rule(2, 16'h2000, 90); set_rule(5, 16'h1000, 30);
      run_txn("hold", 5);
      clear_vec(); set_rule(4, 16'h0300, 127); set_rule(8, 16'h0100, -127);
      run_txn("b2b", 0);

      // Reset during the divide phase discards the transaction.
      clear_vec(); set_rule(0, 16'h1234, 77); set_rule(3, 16'h0100, -3);
      bus.mu = mu_v; bus.s = s_v; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (N + 3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_val("midrst/out_valid", longint'(bus.out_valid), 0);
      check_val("midrst/in_ready", longint'(bus.in_ready), 1);
      check_val("midrst/y", longint'($signed(bus.y)), 0);
      check_val("midrst/zero_den", longint'(bus.zero_den), 0);
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1;
      end
      check_val("midrst/no_stale", seen, 0);
      clear_vec(); set_rule(1, 16'h0800, -60); set_rule(7, 16'h0400, 33);
      run_txn("post_rst", 0);

      for (int t = 0; t < 40; t++) begin
         random_vec();
         run_txn("rand", int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
